board_state_writer: RTL and testbench



---
 rtl/board_state_writer.sv | 152 +++++++++++++++
 tb/tb_board_state_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/board_state_writer.sv
// board_state_writer
// Owns the packed 4x4 sliding-puzzle board and is its only writer. Accepts one
// move at a time over a valid/ready handshake, swaps the blank with the
// neighbouring tile when the move is legal, and supports loading either the
// solved board or an external board image.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   move_valid/move_dir    move request (00 up, 01 down, 10 left, 11 right)
//   move_ready             high when a move can be accepted
//   load_solved            load the solved board (highest command priority)
//   load_board             load board_in / blank_in
//   board_in, blank_in     external board image and its blank cell index
//   numbers, blank_pos     current board image (cell k at [4k+3:4k]) and blank
//   move_done              one-cycle pulse at the end of an accepted move
//   move_legal             legality of the last completed move
//   move_count             saturating count of legal moves since load/reset
//   solved                 combinational: numbers equals the solved image
//
// state | meaning
// IDLE  | ready for a move; move_ready high
// CHECK | compute target cell and legality from latched direction
// SWAP  | apply swap if legal, record legality
// DONE  | move_done pulse, then back to IDLE
module board_state_writer #(
  parameter int COUNT_W = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               move_valid,
  input  logic [1:0]         move_dir,
  output logic               move_ready,
  input  logic               load_solved,
  input  logic               load_board,
  input  logic [63:0]        board_in,
  input  logic [3:0]         blank_in,
  output logic [63:0]        numbers,
  output logic [3:0]         blank_pos,
  output logic               move_done,
  output logic               move_legal,
  output logic [COUNT_W-1:0] move_count,
  output logic               solved
);

  localparam logic [63:0] SOLVED = 64'h0FED_CBA9_8765_4321;

  typedef enum logic [1:0] {IDLE, CHECK, SWAP, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           dir_q, dir_d;
  logic [3:0]           tgt_q, tgt_d;
  logic                 ok_q, ok_d;
  logic [63:0]          board_q, board_d;
  logic [3:0]           blank_q, blank_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 legal_q, legal_d;

  logic                 load_any;
  logic [1:0]           row, col;

  assign load_any = load_solved | load_board;
  assign row      = blank_q[3:2];
  assign col      = blank_q[1:0];

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    ok_d    = ok_q;
    board_d = board_q;
    blank_d = blank_q;
    count_d = count_q;
    legal_d = legal_q;

    if (load_solved) begin
      board_d = SOLVED;
      blank_d = 4'd15;
      count_d = '0;
      legal_d = 1'b0;
      state_d = IDLE;
    end else if (load_board) begin
      board_d = board_in;
      blank_d = blank_in;
      count_d = '0;
      legal_d = 1'b0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (move_valid) begin
            dir_d   = move_dir;
            state_d = CHECK;
          end
        end
        CHECK: begin
          // Target may wrap when illegal; it is ignored in that case.
          unique case (dir_q)
            2'b00: begin ok_d = (row != 2'd0); tgt_d = blank_q - 4'd4; end
            2'b01: begin ok_d = (row != 2'd3); tgt_d = blank_q + 4'd4; end
            2'b10: begin ok_d = (col != 2'd0); tgt_d = blank_q - 4'd1; end
            2'b11: begin ok_d = (col != 2'd3); tgt_d = blank_q + 4'd1; end
          endcase
          state_d = SWAP;
        end
        SWAP: begin
          if (ok_q) begin
            board_d[{blank_q, 2'b00} +: 4] = board_q[{tgt_q, 2'b00} +: 4];
            board_d[{tgt_q, 2'b00} +: 4]   = 4'd0;
            blank_d = tgt_q;
            if (count_q != {COUNT_W{1'b1}}) count_d = count_q + 1'b1;
          end
          legal_d = ok_q;
          state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      dir_q   <= 2'b00;
      tgt_q   <= 4'd0;
      ok_q    <= 1'b0;
      board_q <= SOLVED;
      blank_q <= 4'd15;
      count_q <= '0;
      legal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      ok_q    <= ok_d;
      board_q <= board_d;
      blank_q <= blank_d;
      count_q <= count_d;
      legal_q <= legal_d;
    end
  end

  // A load in the same cycle wins: no acceptance and no completion pulse.
  assign move_ready = (state_q == IDLE) && !load_any;
  assign move_done  = (state_q == DONE) && !load_any;
  assign numbers    = board_q;
  assign blank_pos  = blank_q;
  assign move_legal = legal_q;
  assign move_count = count_q;
  assign solved     = (board_q == SOLVED);

endmodule

// File: tb/tb_board_state_writer.sv
module tb_board_state_writer;

  localparam int COUNT_W = 10;
  localparam logic [63:0] SOLVED = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] UP1    = 64'hCFED_0BA9_8765_4321;
  localparam logic [63:0] REV    = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] REVL   = 64'h1023_4567_89AB_CDEF;

  logic               clk = 1'b0;
  logic               resetn;
  logic               move_valid;
  logic [1:0]         move_dir;
  logic               move_ready;
  logic               load_solved;
  logic               load_board;
  logic [63:0]        board_in;
  logic [3:0]         blank_in;
  logic [63:0]        numbers;
  logic [3:0]         blank_pos;
  logic               move_done;
  logic               move_legal;
  logic [COUNT_W-1:0] move_count;
  logic               solved;

  int vectors = 0;
  int miscompares = 0;

  board_state_writer #(.COUNT_W(COUNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .load_solved(load_solved), .load_board(load_board),
    .board_in(board_in), .blank_in(blank_in),
    .numbers(numbers), .blank_pos(blank_pos),
    .move_done(move_done), .move_legal(move_legal),
    .move_count(move_count), .solved(solved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept at E0, then report state #1 after E2 (move_done cycle).
  task automatic issue_to_done(input logic [1:0] dir);
    @(negedge clk);
    move_valid = 1'b1;
    move_dir   = dir;
    @(posedge clk);
    #1 move_valid = 1'b0;
    move_dir = 2'bxx;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run_move(input logic [1:0] dir);
    issue_to_done(dir);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load_solved;
    @(negedge clk);
    load_solved = 1'b1;
    @(posedge clk);
    #1 load_solved = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; move_valid = 1'b0; move_dir = 2'b00;
    load_solved = 1'b0; load_board = 1'b0; board_in = '0; blank_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_numbers", numbers, SOLVED);
    chk("rst_blank", blank_pos, 15);
    chk("rst_ready", move_ready, 1);
    chk("rst_count", move_count, 0);
    chk("rst_done", move_done, 0);
    resetn = 1'b1;

    // Illegal right from solved
    issue_to_done(2'b11);
    chk("illR_done", move_done, 1);
    chk("illR_legal", move_legal, 0);
    chk("illR_numbers", numbers, SOLVED);
    chk("illR_count", move_count, 0);
    @(posedge clk); #1;
    chk("illR_done_clr", move_done, 0);
    chk("illR_ready", move_ready, 1);

    // Illegal down from solved
    issue_to_done(2'b01);
    chk("illD_done", move_done, 1);
    chk("illD_legal", move_legal, 0);
    chk("illD_numbers", numbers, SOLVED);
    chk("illD_count", move_count, 0);
    @(posedge clk); #1;

    // Legal up from solved
    issue_to_done(2'b00);
    chk("up_done", move_done, 1);
    chk("up_legal", move_legal, 1);
    chk("up_numbers", numbers, UP1);
    chk("up_blank", blank_pos, 11);
    chk("up_count", move_count, 1);
    chk("up_solved", solved, 0);
    @(posedge clk); #1;
    chk("up_done_clr", move_done, 0);
    chk("up_legal_hold", move_legal, 1);

    pulse_load_solved();
    chk("ls_count", move_count, 0);
    chk("ls_legal", move_legal, 0);
    chk("ls_numbers", numbers, SOLVED);

    // Backpressure: valid held high, up then down
    @(negedge clk);
    move_valid = 1'b1; move_dir = 2'b00;
    @(posedge clk);
    #1 move_dir = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp1_ready_low", move_ready, 0);
    end
    chk("bp1_numbers", numbers, UP1);
    @(negedge clk);
    chk("bp_ready_high", move_ready, 1);
    @(posedge clk);
    #1 move_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp2_ready_low", move_ready, 0);
    end
    chk("bp_numbers", numbers, SOLVED);
    chk("bp_count", move_count, 2);
    chk("bp_solved", solved, 1);

    // Mid-move load during CHECK
    @(negedge clk);
    move_valid = 1'b1; move_dir = 2'b00;
    @(posedge clk);
    #1 move_valid = 1'b0;
    load_board = 1'b1; board_in = REV; blank_in = 4'd15;
    @(posedge clk);
    #1 load_board = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ml_no_done", move_done, 0);
    end
    chk("ml_numbers", numbers, REV);
    chk("ml_blank", blank_pos, 15);
    chk("ml_count", move_count, 0);
    chk("ml_ready", move_ready, 1);
    chk("ml_solved", solved, 0);

    // Left from loaded board
    issue_to_done(2'b10);
    chk("left_numbers", numbers, REVL);
    chk("left_blank", blank_pos, 14);
    chk("left_legal", move_legal, 1);
    @(posedge clk); #1;

    // Saturation
    for (int i = 0; i < 1030; i++) run_move((i % 2 == 0) ? 2'b00 : 2'b01);
    chk("sat_count", move_count, 1023);
    chk("sat_numbers", numbers, REVL);
    run_move(2'b00);
    chk("sat_hold", move_count, 1023);
    pulse_load_solved();
    chk("sat_clear", move_count, 0);

    // Reset during SWAP
    @(negedge clk);
    move_valid = 1'b1; move_dir = 2'b00;
    @(posedge clk);
    #1 move_valid = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rs_numbers", numbers, SOLVED);
    chk("rs_blank", blank_pos, 15);
    chk("rs_ready", move_ready, 1);
    chk("rs_solved", solved, 1);
    chk("rs_count", move_count, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("rs_after_numbers", numbers, SOLVED);
    chk("rs_after_done", move_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
